color_flash_unit: RTL and testbench

- Holds the character and background colours for the VGA character display, and produces the flash gating signal.
- Sits behind the keypad/input decoder. That decoder emits one-hot colour-step flags, a background-select level and a flash-enable level.
- Outputs feed the pixel mux: 9-bit RGB333 char/bg colours, plus flash_clk, which blanks the character when low.

---
 rtl/color_flash_unit_pkg.sv | 30 +++
 rtl/color_flash_unit_flash_divider.sv | 33 +++
 rtl/color_flash_unit.sv | 70 +++++++
 tb/tb_color_flash_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/color_flash_unit_pkg.sv
// rtl/color_flash_unit_pkg.sv - shared constants for the colour/flash unit
package color_flash_unit_pkg;

  // Bits per colour channel and the packed RGB word width
  localparam int CH_W  = 3;
  localparam int RGB_W = 3 * CH_W;

  // Channel index as seen on the user_color step flags
  localparam int R_IDX = 0;
  localparam int G_IDX = 1;
  localparam int B_IDX = 2;

  // Channel slice positions inside the default 9-bit word
  localparam int R_HI = 8;
  localparam int R_LO = 6;
  localparam int G_HI = 5;
  localparam int G_LO = 3;
  localparam int B_HI = 2;
  localparam int B_LO = 0;

  // Reset colours: white character on a black background
  localparam logic [RGB_W-1:0] CHAR_RST = 9'h1FF;
  localparam logic [RGB_W-1:0] BG_RST   = 9'h000;

  // Low bit of a channel slice; red sits in the top slice, blue in the bottom
  function automatic int chanLo(input int idx, input int chW);
    return (2 - idx) * chW;
  endfunction

endpackage

// File: rtl/color_flash_unit_flash_divider.sv
// rtl/color_flash_unit_flash_divider.sv - square-wave flash gate generator
module flash_divider #(
  parameter int FLASH_HALF = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic en_flash,
  output logic flash_clk
);

  localparam int CNT_W = $clog2(FLASH_HALF);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FLASH_HALF - 1);

  logic [CNT_W-1:0] halfCnt;

  // Count half-periods while enabled; disabling parks the gate high so a
  // re-enable always starts with a full visible phase
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halfCnt   <= '0;
      flash_clk <= 1'b1;
    end else if (!en_flash) begin
      halfCnt   <= '0;
      flash_clk <= 1'b1;
    end else if (halfCnt == LAST) begin
      halfCnt   <= '0;
      flash_clk <= ~flash_clk;
    end else begin
      halfCnt   <= halfCnt + 1'b1;
    end
  end

endmodule

// File: rtl/color_flash_unit.sv
// rtl/color_flash_unit.sv - character/background colour registers with flash gate
module color_flash_unit #(
  parameter int                   CH_W       = color_flash_unit_pkg::CH_W,
  parameter logic [3*CH_W-1:0]    CHAR_RST   = color_flash_unit_pkg::CHAR_RST,
  parameter logic [3*CH_W-1:0]    BG_RST     = color_flash_unit_pkg::BG_RST,
  parameter int                   FLASH_HALF = 25_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en_bg,
  input  logic [2:0]        user_color,
  input  logic              en_flash,
  output logic [3*CH_W-1:0] char_rgb,
  output logic [3*CH_W-1:0] bg_rgb,
  output logic              flash_clk
);

  import color_flash_unit_pkg::*;

  localparam int WORD_W = 3 * CH_W;

  logic [2:0]        prevColor;
  logic [2:0]        step;
  logic [WORD_W-1:0] stepped;
  logic [WORD_W-1:0] charNext;
  logic [WORD_W-1:0] bgNext;

  assign step = user_color & ~prevColor;

  // Apply one increment per rising flag to the selected word; channels wrap
  // independently so no carry leaks into the neighbour
  always_comb begin
    charNext = char_rgb;
    bgNext   = bg_rgb;
    stepped  = en_bg ? bg_rgb : char_rgb;
    for (int i = R_IDX; i <= B_IDX; i++) begin
      if (step[i]) begin
        stepped[chanLo(i, CH_W) +: CH_W] = stepped[chanLo(i, CH_W) +: CH_W] + 1'b1;
      end
    end
    if (en_bg) begin
      bgNext = stepped;
    end else begin
      charNext = stepped;
    end
  end

  // Colour words and flag history; history makes a held flag count once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prevColor <= '0;
      char_rgb  <= CHAR_RST;
      bg_rgb    <= BG_RST;
    end else begin
      prevColor <= user_color;
      char_rgb  <= charNext;
      bg_rgb    <= bgNext;
    end
  end

  flash_divider #(
    .FLASH_HALF(FLASH_HALF)
  ) flashDivider (
    .clock    (clock),
    .reset    (reset),
    .en_flash (en_flash),
    .flash_clk(flash_clk)
  );

endmodule

// File: tb/tb_color_flash_unit.sv
// tb/tb_color_flash_unit.sv - self-checking bench for color_flash_unit
module tb_color_flash_unit;

  localparam int FH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       en_bg = 1'b0;
  logic       en_flash = 1'b0;
  logic [2:0] user_color = 3'b000;
  logic [8:0] char_rgb;
  logic [8:0] bg_rgb;
  logic       flash_clk;

  int errors = 0;
  int checks = 0;
  bit cmpEn = 1'b0;

  color_flash_unit #(
    .FLASH_HALF(FH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .en_bg     (en_bg),
    .user_color(user_color),
    .en_flash  (en_flash),
    .char_rgb  (char_rgb),
    .bg_rgb    (bg_rgb),
    .flash_clk (flash_clk)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: colours as three integer channels, flash phase from edges-since-enable
  logic [8:0] mChar;
  logic [8:0] mBg;
  logic [2:0] mPrev;
  logic [2:0] mRise;
  int         mEnCnt;

  function automatic logic [8:0] bump(input logic [8:0] w, input logic [2:0] flags);
    int r, g, b;
    r = int'(w) / 64;
    g = (int'(w) / 8) % 8;
    b = int'(w) % 8;
    if (flags[0]) r = (r + 1) % 8;
    if (flags[1]) g = (g + 1) % 8;
    if (flags[2]) b = (b + 1) % 8;
    return 9'(r * 64 + g * 8 + b);
  endfunction

  function automatic logic modelFlash(input int n);
    return ((n / FH) % 2) == 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mChar  = 9'h1FF;
      mBg    = 9'h000;
      mPrev  = 3'b000;
      mEnCnt = 0;
    end else begin
      mRise = user_color & ~mPrev;
      if (en_bg) mBg = bump(mBg, mRise);
      else       mChar = bump(mChar, mRise);
      mPrev = user_color;
      if (en_flash) mEnCnt++;
      else          mEnCnt = 0;
    end
  end

  always @(negedge clock) begin
    if (cmpEn && !reset) begin
      check("model_char", char_rgb, mChar);
      check("model_bg", bg_rgb, mBg);
      check("model_flash", {8'b0, flash_clk}, {8'b0, modelFlash(mEnCnt)});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset asserted between edges; outputs must recover without a clock edge
  task automatic midReset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_char"}, char_rgb, 9'h1FF);
    check({tag, "_bg"}, bg_rgb, 9'h000);
    check({tag, "_flash"}, {8'b0, flash_clk}, 9'h001);
    tick();
    reset = 1'b0;
  endtask

  logic flashExp [12] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};

  initial begin
    tick();
    tick();
    check("rst_char", char_rgb, 9'h1FF);
    check("rst_bg", bg_rgb, 9'h000);
    check("rst_flash", {8'b0, flash_clk}, 9'h001);
    reset = 1'b0;
    cmpEn = 1'b1;

    // All three channels of the background in one cycle
    en_bg = 1'b1;
    user_color = 3'b111;
    tick();
    user_color = 3'b000;
    check("all_bg", bg_rgb, 9'h049);
    check("all_char_hold", char_rgb, 9'h1FF);
    tick();
    midReset("rst2");

    // Single red pulse, then a long hold that must count once
    en_bg = 1'b1;
    user_color = 3'b001;
    tick();
    check("pulse_bg", bg_rgb, 9'h040);
    user_color = 3'b000;
    tick();
    user_color = 3'b001;
    repeat (10) tick();
    check("hold_bg", bg_rgb, 9'h080);
    user_color = 3'b000;
    tick();

    // Toggling the target select alone changes nothing
    en_bg = 1'b0;
    tick();
    en_bg = 1'b1;
    tick();
    en_bg = 1'b0;
    tick();
    check("sel_bg", bg_rgb, 9'h080);
    check("sel_char", char_rgb, 9'h1FF);

    // Eight blue pulses on the character: wrap on the first, home after all
    for (int p = 0; p < 8; p++) begin
      user_color = 3'b100;
      tick();
      if (p == 0) check("blue_wrap", char_rgb, 9'h1F8);
      user_color = 3'b000;
      tick();
    end
    check("blue_home", char_rgb, 9'h1FF);
    check("blue_bg_hold", bg_rgb, 9'h080);

    // Flash pattern with half period FH
    en_flash = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("flash_%0d", k), {8'b0, flash_clk}, {8'b0, flashExp[k]});
    end
    en_flash = 1'b0;
    tick();
    check("flash_drop", {8'b0, flash_clk}, 9'h001);
    tick();
    tick();
    check("flash_stay", {8'b0, flash_clk}, 9'h001);

    // Flash enable and a green step in the same cycle
    en_bg = 1'b0;
    en_flash = 1'b1;
    user_color = 3'b010;
    tick();
    check("both_char", char_rgb, 9'h1C7);
    check("both_flash", {8'b0, flash_clk}, 9'h001);
    repeat (3) tick();
    check("both_char_once", char_rgb, 9'h1C7);
    check("both_flash_low", {8'b0, flash_clk}, 9'h000);
    user_color = 3'b000;
    tick();

    // Reset while flashing low with a modified character colour
    midReset("rst3");
    tick();
    check("post_rst_flash", {8'b0, flash_clk}, 9'h001);
    en_flash = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
